// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALT sequencing, seq/jal/jalr/trap redirect, sticky misalign.
// Optional return-address stack built when FETCH_PC_RAS_EN is defined.
module fetch_pc_gen #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(64'h7ffffffc),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            fetch_ready,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic            misalign_err,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] target;
  logic            sel_ok;
  logic            xfer;       // accepted, well-formed, aligned transfer

  always_comb begin
    target = '0;
    sel_ok = 1'b1;
    case (pc_sel)
      3'b001:  target = pc_q + XLEN'(4);
      3'b010:  target = pc_q + {imm[XLEN-2:0], 1'b0};
      3'b100:  target = (rs1 + imm) & ~XLEN'(1);
      default: sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    xfer    = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap_valid) begin
          pc_d  = trap_vec & ~XLEN'(3);
          err_d = 1'b0;
        end else if (fetch_ready && sel_ok) begin
          if (target[1]) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d = target;
            xfer = 1'b1;
          end
        end
      end
      HALT: begin
        if (trap_valid) begin
          pc_d    = trap_vec & ~XLEN'(3);
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign pc           = pc_q;
  assign fetch_valid  = (state_q == RUN);
  assign misalign_err = err_q;

`ifdef FETCH_PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = RAS_DEPTH[PTR_W:0];

  // ptr points at the next free slot; cnt saturates so overwrite-oldest stays circular
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [XLEN-1:0]  ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]  ret_addr;

  assign top_idx  = ptr_q - 1'b1;
  assign ret_addr = pc_q + XLEN'(4);

  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (xfer) begin
      if (ras_push && ras_pop && cnt_q != '0) begin
        ras_d[top_idx] = ret_addr;
      end else if (ras_push) begin
        ras_d[ptr_q] = ret_addr;
        ptr_d        = ptr_q + 1'b1;
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
      end else if (ras_pop && cnt_q != '0) begin
        ptr_d = top_idx;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ras_q <= ras_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ras_empty = (cnt_q == '0);
  assign ras_top   = ras_empty ? '0 : ras_q[top_idx];
`else
  logic unused_ras;
  assign unused_ras = ras_push ^ ras_pop ^ xfer;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen (XLEN=64); RAS checks follow FETCH_PC_RAS_EN.
module tb_fetch_pc_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  pc_sel = 3'b000;
  logic [63:0] rs1 = '0, imm = '0, trap_vec = '0;
  logic        fetch_ready = 1'b0, trap_valid = 1'b0, ras_push = 1'b0, ras_pop = 1'b0;
  logic [63:0] pc, ras_top;
  logic        fetch_valid, misalign_err, ras_empty;
  int          checks = 0;
  int          errors = 0;

  fetch_pc_gen dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .rs1(rs1), .imm(imm),
    .fetch_ready(fetch_ready), .trap_valid(trap_valid), .trap_vec(trap_vec),
    .ras_push(ras_push), .ras_pop(ras_pop), .pc(pc), .fetch_valid(fetch_valid),
    .misalign_err(misalign_err), .ras_top(ras_top), .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input logic [63:0] epc, input logic efv, input logic eerr);
    chk({tag, "_pc"}, pc, epc);
    chk({tag, "_fv"}, {63'b0, fetch_valid}, {63'b0, efv});
    chk({tag, "_err"}, {63'b0, misalign_err}, {63'b0, eerr});
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    status("rst_async", 64'h7ffffffc, 1'b0, 1'b0);
    chk("rst_empty", {63'b0, ras_empty}, 64'd1);
    chk("rst_top", ras_top, 64'd0);
    tick(); tick();
    rst = 1'b0;
    status("boot", 64'h7ffffffc, 1'b0, 1'b0);
    tick();
    status("run_entry", 64'h7ffffffc, 1'b1, 1'b0);

    pc_sel = 3'b001; fetch_ready = 1'b1;
    tick();
    status("seq", 64'h80000000, 1'b1, 1'b0);

    pc_sel = 3'b010; imm = 64'h10; fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      status("jal_stall", 64'h80000000, 1'b1, 1'b0);
    end
    fetch_ready = 1'b1;
    tick();
    status("jal", 64'h80000020, 1'b1, 1'b0);

    pc_sel = 3'b000;
    tick();
    status("sel_zero", 64'h80000020, 1'b1, 1'b0);
    pc_sel = 3'b011;
    tick();
    status("sel_multi", 64'h80000020, 1'b1, 1'b0);

    pc_sel = 3'b100; rs1 = 64'h1000; imm = 64'h5;
    tick();
    status("jalr", 64'h1004, 1'b1, 1'b0);

    rs1 = 64'h80001001; imm = 64'h1;
    tick();
    status("jalr_misalign", 64'h1004, 1'b0, 1'b1);
    pc_sel = 3'b001;
    tick();
    status("halt_hold", 64'h1004, 1'b0, 1'b1);

    trap_valid = 1'b1; trap_vec = 64'h100;
    tick();
    trap_valid = 1'b0;
    status("trap_halt", 64'h100, 1'b1, 1'b0);

    trap_valid = 1'b1; trap_vec = 64'hFFFFFFFFFFFFFFFF; fetch_ready = 1'b0;
    tick();
    trap_valid = 1'b0; fetch_ready = 1'b1;
    status("trap_run_mask", 64'hFFFFFFFFFFFFFFFC, 1'b1, 1'b0);
    pc_sel = 3'b001;
    tick();
    status("seq_wrap", 64'h0, 1'b1, 1'b0);

    pc_sel = 3'b010; imm = 64'hFFFFFFFFFFFFFFFE;
    tick();
    status("jal_neg", 64'hFFFFFFFFFFFFFFFC, 1'b1, 1'b0);
    imm = 64'h1;
    tick();
    status("jal_misalign", 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b1);

    trap_valid = 1'b1; trap_vec = 64'h200; pc_sel = 3'b001;
    tick();
    trap_valid = 1'b0;
    status("trap2", 64'h200, 1'b1, 1'b0);

`ifdef FETCH_PC_RAS_EN
    // pushes at A..E = 0x200..0x210; depth 4 keeps B..E returns
    ras_push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ras_push_top", ras_top, 64'h204 + 64'(4 * i));
    end
    chk("ras_push_pc", pc, 64'h214);
    ras_push = 1'b0; ras_pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ras_pop_top", ras_top, 64'h210 - 64'(4 * i));
      chk("ras_pop_empty", {63'b0, ras_empty}, 64'd0);
    end
    tick();
    chk("ras_pop4_empty", {63'b0, ras_empty}, 64'd1);
    chk("ras_pop4_top", ras_top, 64'd0);
    tick();
    chk("ras_pop5_empty", {63'b0, ras_empty}, 64'd1);
    // pc now 0x228
    ras_pop = 1'b0; ras_push = 1'b1; fetch_ready = 1'b0;
    tick();
    chk("ras_noacc", {63'b0, ras_empty}, 64'd1);
    fetch_ready = 1'b1;
    tick();
    chk("ras_push1", ras_top, 64'h22c);
    ras_pop = 1'b1;
    tick();
    chk("ras_replace", ras_top, 64'h230);
    ras_push = 1'b0;
    tick();
    chk("ras_replace_pop", {63'b0, ras_empty}, 64'd1);
    ras_pop = 1'b0;
`else
    ras_push = 1'b1;
    tick(); tick();
    ras_push = 1'b0; ras_pop = 1'b1;
    tick();
    ras_pop = 1'b0;
    chk("noras_empty", {63'b0, ras_empty}, 64'd1);
    chk("noras_top", ras_top, 64'd0);
`endif

    // reset asserted mid-transfer discards it immediately
    pc_sel = 3'b001; fetch_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    status("rst_mid", 64'h7ffffffc, 1'b0, 1'b0);
    chk("rst_mid_empty", {63'b0, ras_empty}, 64'd1);
    tick();
    rst = 1'b0;
    tick();
    status("rst_run", 64'h7ffffffc, 1'b1, 1'b0);
    tick();
    status("rst_seq", 64'h80000000, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the width of every address/data port and of the PC register.
REQ-002 Parameter RESET_PC, default 64'h7ffffffc (truncated to XLEN), SHALL set the PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4, power of two, 2..16, SHALL set return-address-stack entry count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pc_sel  input  3  one-hot next-PC select: 001 seq (pc+4), 010 jal (pc+imm*2), 100 jalr ((rs1+imm)&~1).
REQ-007 rs1  input  XLEN  jalr base register value.
REQ-008 imm  input  XLEN  sign-extended immediate.
REQ-009 fetch_ready  input  1  consumer accepts current pc this cycle.
REQ-010 trap_valid  input  1  trap redirect request; highest priority.
REQ-011 trap_vec  input  XLEN  trap handler address.
REQ-012 ras_push  input  1  push pc+4 on the accepted transfer (call).
REQ-013 ras_pop  input  1  pop on the accepted transfer (return).
REQ-014 pc  output  XLEN  current fetch address (registered).
REQ-015 fetch_valid  output  1  pc is valid for fetch.
REQ-016 misalign_err  output  1  sticky: computed target not 4-byte aligned.
REQ-017 ras_top  output  XLEN  top-of-stack prediction; ras_empty  output  1  stack empty.

Function
REQ-018 States SHALL be BOOT, RUN, HALT; reset enters BOOT.
REQ-019 BOOT: fetch_valid=0; SHALL move to RUN on the next edge unconditionally.
REQ-020 RUN: fetch_valid=1; pc SHALL update only on accept (fetch_valid & fetch_ready); no accept -> pc, RAS held.
REQ-021 Next PC on accept: 001 -> pc+4; 010 -> pc+{imm[XLEN-2:0],1'b0}; 100 -> (rs1+imm)&~1; all sums modulo 2^XLEN (wrap, no carry out).
REQ-022 pc_sel zero or multi-hot on accept SHALL hold pc unchanged (no update, no RAS action).
REQ-023 Target with bit[1]=1 on accept SHALL not be loaded; misalign_err set, state -> HALT, pc held.
REQ-024 HALT: fetch_valid=0, misalign_err=1, pc held; only trap_valid or rst leaves HALT.
REQ-025 trap_valid in any non-BOOT state SHALL load pc=trap_vec&~3, clear misalign_err, enter RUN next cycle, ignore pc_sel/ras_* that cycle, regardless of fetch_ready.
REQ-026 trap_valid during BOOT SHALL be ignored.
REQ-027 Latency: new pc visible exactly one cycle after the accepting edge.

Reset
REQ-028 On rst (async assert): pc=RESET_PC, fetch_valid=0, misalign_err=0, state=BOOT, RAS pointer=0, ras_empty=1, ras_top=0.
REQ-029 rst asserted mid-transfer SHALL discard the transfer; deassertion is sampled synchronously by clk.

Configuration
REQ-030 Macro FETCH_PC_RAS_EN defined: RAS of RAS_DEPTH entries built; push stores old pc+4, pop removes top; push & pop together SHALL replace top (pointer unchanged); push when full overwrites oldest (circular, pointer wraps); pop when empty ignored.
REQ-031 Macro undefined: no RAS storage; ras_top=0, ras_empty=1 constantly; ras_push/ras_pop ignored.

Verification
REQ-032 Reset, XLEN=64 -> pc=0x7ffffffc, fetch_valid=0; next cycle fetch_valid=1; pc_sel=001, ready=1 -> pc=0x80000000.
REQ-033 pc=0x80000000, pc_sel=010, imm=0x10, ready=1 -> pc=0x80000020; same with ready=0 for 3 cycles -> pc held 0x80000000.
REQ-034 pc_sel=100, rs1=0x80001001, imm=0x1 -> pc=0x80001002 & misalign -> misalign_err=1, HALT, pc held; then trap_valid, trap_vec=0x100 -> pc=0x100, err=0, RUN.
REQ-035 pc=0xFFFFFFFFFFFFFFFC, pc_sel=001 -> pc=0x0 (wrap).
REQ-036 FETCH_PC_RAS_EN, RAS_DEPTH=4: 5 pushes at pc=A..E -> ras_top=E+4, 4 pops then ras_empty=1, 5th pop no change; undefined -> ras_empty stays 1.
